// File: rtl/tone_scheduler.sv
// rtl/tone_scheduler.sv - queues game sound events and plays them one at a time on a shared tone generator
module tone_scheduler #(
    parameter int DUR_CYCLES = 25_000_000,
    parameter int GAP_CYCLES = 2_500_000,
    parameter int HP_ALARM   = 16384,
    parameter int HP_RANK1   = 32768,
    parameter int HP_RANK2   = 8192,
    parameter int HP_RANK3   = 65536,
    parameter int HP_W       = 18
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alarm_in,
    input  logic            rank1_in,
    input  logic            rank2_in,
    input  logic            rank3_in,
    output logic            tone_en,
    output logic [1:0]      tone_id,
    output logic [HP_W-1:0] tone_half_period,
    output logic            busy,
    output logic [3:0]      pending
);

    localparam int MAX_CYC = (DUR_CYCLES > GAP_CYCLES) ? DUR_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] DUR_LOAD = CW'(DUR_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_tone_en;
    logic [1:0]        r_tone_id;
    logic [HP_W-1:0]   r_hp;
    logic              r_busy;
    logic [3:0]        r_pending;
    logic [3:0]        r_prev;
    logic              r_armed;

    logic [3:0]        w_in;
    logic [3:0]        w_evt;
    logic [1:0]        w_gnt_id;
    logic [3:0]        w_gnt_mask;
    logic              w_take;
    logic              w_preempt;

    // Half-period lookup for a granted source
    function automatic logic [HP_W-1:0] hp_of(input logic [1:0] id);
        case (id)
            2'd0:    hp_of = HP_W'(HP_ALARM);
            2'd1:    hp_of = HP_W'(HP_RANK1);
            2'd2:    hp_of = HP_W'(HP_RANK2);
            default: hp_of = HP_W'(HP_RANK3);
        endcase
    endfunction

    assign w_in = {rank3_in, rank2_in, rank1_in, alarm_in};

    // Alarm fires on a rising edge only; rank signals fire on any toggle; nothing fires until armed
    always_comb begin
        w_evt = 4'b0000;
        if (r_armed) begin
            w_evt[0]   = w_in[0] & ~r_prev[0];
            w_evt[3:1] = w_in[3:1] ^ r_prev[3:1];
        end
    end

    // Fixed-priority pick of the lowest-numbered pending source
    always_comb begin
        w_gnt_id   = 2'd0;
        w_gnt_mask = 4'b0000;
        if (r_pending[0]) begin
            w_gnt_id   = 2'd0;
            w_gnt_mask = 4'b0001;
        end else if (r_pending[1]) begin
            w_gnt_id   = 2'd1;
            w_gnt_mask = 4'b0010;
        end else if (r_pending[2]) begin
            w_gnt_id   = 2'd2;
            w_gnt_mask = 4'b0100;
        end else if (r_pending[3]) begin
            w_gnt_id   = 2'd3;
            w_gnt_mask = 4'b1000;
        end
    end

    // A grant happens from IDLE, or from the last GAP cycle, whenever something is queued
    assign w_take    = (|r_pending) &&
                       ((r_state == S_IDLE) || ((r_state == S_GAP) && (r_cnt == '0)));
    // A queued alarm cuts a rank tone short; an alarm tone is never cut
    assign w_preempt = (r_state == S_PLAY) && (r_tone_id != 2'd0) && r_pending[0];

    // Sample previous input levels; the first cycle after reset only arms the detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev  <= 4'b0000;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= w_in;
            r_armed <= 1'b1;
        end
    end

    // Pending set/clear; a new event on the source being granted keeps its bit set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 4'b0000;
        end else begin
            r_pending <= (r_pending & ~(w_take ? w_gnt_mask : 4'b0000)) | w_evt;
        end
    end

    // Play/gap sequencer with registered tone outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tone_en <= 1'b0;
            r_tone_id <= 2'd0;
            r_hp      <= '0;
            r_busy    <= 1'b0;
        end else if (w_take) begin
            r_state   <= S_PLAY;
            r_cnt     <= DUR_LOAD;
            r_tone_en <= 1'b1;
            r_tone_id <= w_gnt_id;
            r_hp      <= hp_of(w_gnt_id);
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                S_PLAY: begin
                    if (w_preempt || (r_cnt == '0)) begin
                        r_state   <= S_GAP;
                        r_cnt     <= GAP_LOAD;
                        r_tone_en <= 1'b0;
                        r_hp      <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    r_tone_en <= 1'b0;
                    r_hp      <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign tone_en          = r_tone_en;
    assign tone_id          = r_tone_id;
    assign tone_half_period = r_hp;
    assign busy             = r_busy;
    assign pending          = r_pending;

endmodule
